// File: rtl/counter.sv
// Free-running up-counter with wrap pulse, terminal-value decode and a
// registered Gray-coded copy of the count.
module counter #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [32:0] MAX_COUNT   = (33'd1 << WIDTH) - 33'd1,
  parameter logic [32:0] RESET_VALUE = 33'd0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             at_max,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter: WIDTH must be in 2..32");
  end
  if (MAX_COUNT > ((33'd1 << WIDTH) - 33'd1)) begin : g_bad_max
    $fatal(1, "counter: MAX_COUNT does not fit in WIDTH bits");
  end
  if (RESET_VALUE > MAX_COUNT) begin : g_bad_reset
    $fatal(1, "counter: RESET_VALUE must not exceed MAX_COUNT");
  end

  localparam logic [WIDTH-1:0] MAX_V  = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] GRAY_R = RST_V ^ (RST_V >> 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_max_w;

  assign at_max_w = (count_q == MAX_V);

  // Gray copy is derived from the next count so it never lags the binary value.
  always_comb begin
    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    wrap_d  = 1'b0;
    if (at_max_w) begin
      count_d = RST_V;
      wrap_d  = 1'b1;
    end
    gray_d = count_d ^ (count_d >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_V;
      gray_q  <= GRAY_R;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign count_gray = gray_q;
  assign at_max     = at_max_w;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: three parameterisations share clock and reset and are
// checked every cycle against an edge-count model, with random async resets.
module tb_counter;

  logic clk;
  logic reset;

  logic [7:0] def_count, def_gray;
  logic       def_at_max, def_wrap;
  logic [7:0] mod_count, mod_gray;
  logic       mod_at_max, mod_wrap;
  logic [3:0] deg_count, deg_gray;
  logic       deg_at_max, deg_wrap;

  int checks;
  int errors;
  int n_edges;
  bit running;
  bit have_prev;
  logic [7:0] prev_count, prev_gray;

  counter u_def (
    .clk(clk), .reset(reset), .count(def_count), .count_gray(def_gray),
    .at_max(def_at_max), .wrap(def_wrap)
  );

  counter #(.WIDTH(8), .MAX_COUNT(33'd9), .RESET_VALUE(33'd3)) u_mod (
    .clk(clk), .reset(reset), .count(mod_count), .count_gray(mod_gray),
    .at_max(mod_at_max), .wrap(mod_wrap)
  );

  counter #(.WIDTH(4), .MAX_COUNT(33'd5), .RESET_VALUE(33'd5)) u_deg (
    .clk(clk), .reset(reset), .count(deg_count), .count_gray(deg_gray),
    .at_max(deg_at_max), .wrap(deg_wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: rising edges seen since reset was last released
  always @(posedge clk or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  function automatic int exp_cnt(input int rv, input int mx, input int n);
    return rv + (n % (mx - rv + 1));
  endfunction

  function automatic int exp_wrap(input int rv, input int mx, input int n);
    return (n > 0 && (n % (mx - rv + 1)) == 0) ? 1 : 0;
  endfunction

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string name, input int rv, input int mx,
                            input logic [31:0] c, input logic [31:0] g,
                            input logic am, input logic w);
    int n;
    int ec;
    n  = reset ? 0 : n_edges;
    ec = exp_cnt(rv, mx, n);
    check({name, "_count"}, c, ec);
    check({name, "_gray"}, g, gray_of(ec));
    check({name, "_at_max"}, {31'd0, am}, (ec == mx) ? 1 : 0);
    check({name, "_wrap"}, {31'd0, w}, reset ? 0 : exp_wrap(rv, mx, n));
  endtask

  task automatic compare_all();
    check_inst("def", 0, 255, {24'd0, def_count}, {24'd0, def_gray}, def_at_max, def_wrap);
    check_inst("mod", 3, 9, {24'd0, mod_count}, {24'd0, mod_gray}, mod_at_max, mod_wrap);
    check_inst("deg", 5, 5, {28'd0, deg_count}, {28'd0, deg_gray}, deg_at_max, deg_wrap);
  endtask

  // scoreboard: every cycle, plus single-bit Gray steps on the default counter
  always @(negedge clk) begin
    if (running) begin
      compare_all();
      if (have_prev && !reset && def_count == prev_count + 8'd1)
        check("def_gray_step", $countones(def_gray ^ prev_gray), 1);
      have_prev  = !reset;
      prev_count = def_count;
      prev_gray  = def_gray;
    end
  end

  // driver tasks
  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset(input int offset, input int hold);
    @(posedge clk);
    #(offset);
    reset = 1'b1;
    #1;
    compare_all();
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    running = 1'b0;
    have_prev = 1'b0;
    reset   = 1'b1;
    #1;
    running = 1'b1;
    check("rst_def_count", {24'd0, def_count}, 0);
    check("rst_def_wrap", {31'd0, def_wrap}, 0);
    check("rst_deg_at_max", {31'd0, deg_at_max}, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_edges(20);
    check("lit_count20", {24'd0, def_count}, 20);
    check("lit_wrap0", {31'd0, def_wrap}, 0);

    run_edges(80);
    check("lit_count100", {24'd0, def_count}, 100);
    #2;
    reset = 1'b1;
    #1;
    check("lit_async_count", {24'd0, def_count}, 0);
    check("lit_async_gray", {24'd0, def_gray}, 0);
    check("lit_async_wrap", {31'd0, def_wrap}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_edges(1);
    check("lit_resume1", {24'd0, def_count}, 1);
    check("lit_mod_first", {24'd0, mod_count}, 4);
    check("lit_deg_count", {28'd0, deg_count}, 5);
    check("lit_deg_wrap", {31'd0, deg_wrap}, 1);
    run_edges(6);
    check("lit_mod_wrapval", {24'd0, mod_count}, 3);
    check("lit_mod_wrap", {31'd0, mod_wrap}, 1);
    run_edges(248);
    check("lit_count255", {24'd0, def_count}, 255);
    check("lit_at_max255", {31'd0, def_at_max}, 1);
    run_edges(1);
    check("lit_wrap_count0", {24'd0, def_count}, 0);
    check("lit_wrap_pulse", {31'd0, def_wrap}, 1);
    run_edges(1);
    check("lit_after_wrap1", {24'd0, def_count}, 1);
    check("lit_after_wrap0", {31'd0, def_wrap}, 0);

    for (int i = 0; i < 20; i++) begin
      run_edges($urandom_range(1, 400));
      async_reset($urandom_range(1, 4), $urandom_range(1, 3));
    end
    run_edges(300);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter.md
# counter

Free-running, parameterizable up-counter with wrap detection and a Gray-coded copy of the count. It is a self-contained timebase with no enable or load inputs, used wherever a block needs a cycle count since reset or a periodic wrap tick. All outputs are registered except `at_max`, which is decoded from the count register.

## Interface

Parameters:
- `WIDTH`, default 8: counter width in bits; legal range 2..32.
- `MAX_COUNT`, default 2**WIDTH-1: terminal value; after this value the count wraps. Must satisfy RESET_VALUE ≤ MAX_COUNT ≤ 2**WIDTH-1.
- `RESET_VALUE`, default 0: value loaded on reset and on wrap.
- Illegal parameter combinations stop elaboration with a fatal assertion.

Ports:
- `clk`  input  1: the single clock; all state changes on its rising edge.
- `reset`  input  1: asynchronous, active-high reset; forces all state immediately.
- `count`  output  WIDTH: current count value, registered.
- `count_gray`  output  WIDTH: Gray code of `count`, computed as count ^ (count >> 1), registered, same cycle alignment as `count`.
- `at_max`  output  1: high while `count` == MAX_COUNT; combinational decode of the register.
- `wrap`  output  1: registered single-cycle pulse, high in the cycle after `count` wraps from MAX_COUNT to RESET_VALUE.

## Operation

- There is one clock domain and no other inputs besides `reset`.
- While `reset` is high:
  - `count` = RESET_VALUE and `count_gray` = gray(RESET_VALUE).
  - `wrap` = 0, and `at_max` = (RESET_VALUE == MAX_COUNT).
- Each rising `clk` edge with `reset` low:
  - If `count` == MAX_COUNT: `count` ← RESET_VALUE and `wrap` ← 1.
  - Otherwise: `count` ← `count` + 1 and `wrap` ← 0.
- Arithmetic is unsigned, modulo 2**WIDTH. With default parameters the wrap is natural overflow from 8'hFF to 8'h00.
- `count_gray` is updated in the same edge from the next value of `count`. It never lags `count`, and adjacent values differ by exactly one bit, including across a natural power-of-two wrap.
- Degenerate case MAX_COUNT == RESET_VALUE: `count` holds constant, `at_max` stays 1, and `wrap` pulses every cycle after reset release.
- There are no X or Z propagation paths; every register has a reset value.

## Timing

- Reset assertion takes effect asynchronously, with no clock needed. Reset deassertion is sampled at the next rising edge.
- The first rising edge with `reset` low produces RESET_VALUE+1.
- After reset deasserts, the count after N rising edges is (RESET_VALUE + N) modulo the wrap period, where the period is MAX_COUNT − RESET_VALUE + 1.
- Latency from `count` == MAX_COUNT to the `wrap` pulse is one edge. The pulse is coincident with `count` == RESET_VALUE and lasts exactly one cycle.
- `at_max` is high for exactly one cycle per period, in the cycle before `wrap`.
- Reset asserted mid-count, including in the cycle where `wrap` would pulse: all outputs return to reset values immediately, and the pending `wrap` is dropped.

## Test plan

- Defaults (WIDTH=8), 10-unit clock: hold `reset` high for 20 units and release on a falling edge, then run 200 units. Required: `count`=0 during reset, then 1, 2, … and `count` == 20 at the end; `wrap` stays 0 throughout.
- Defaults, 260 edges after release. Required: `at_max`=1 when `count`=255; next edge gives `count`=0 with `wrap`=1 for exactly one cycle; then `count`=1 with `wrap`=0.
- MAX_COUNT=9, RESET_VALUE=3. Required: the sequence is 3,4,…,9,3,4,… with period 7; `wrap` pulses coincide with `count`=3.
- Gray check over a full default period. Required: `count_gray` == count^(count>>1) every cycle, and successive values have a Hamming distance of 1, including 255→0.
- Assert `reset` asynchronously between edges while `count`=100. Required: `count`=0, `count_gray`=0 and `wrap`=0 before the next edge; counting resumes at 1 after release.
- MAX_COUNT == RESET_VALUE=5. Required: `count` stays 5, `at_max`=1, and `wrap`=1 every cycle after release.
